// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the sequential multiply/divide unit.
//   - MD_* opcodes (3-bit) driven by the E-stage decoder on mdu_seq.op
//   - mdu_state_t : controller state encoding (IDLE / MUL / DIV)
//   - default busy latencies for multiply and divide
//   - CNT_W       : width of the latency counter
// ---------------------------------------------------------------------------
package mdu_pkg;

   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MTHI  = 3'd4;
   localparam logic [2:0] MD_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } mdu_state_t;

   localparam int unsigned MULT_CYCLES_DEF = 5;
   localparam int unsigned DIV_CYCLES_DEF  = 10;
   localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/mdu_div.sv
// ---------------------------------------------------------------------------
// mdu_div
// Combinational 32-bit signed/unsigned divider.
//   a         in  32  dividend
//   b         in  32  divisor
//   is_signed in  1   1 = two's-complement divide, 0 = unsigned divide
//   q         out 32  quotient, truncated toward zero
//   r         out 32  remainder, same sign as the dividend
// Divide by zero returns q = all ones, r = a.
// 0x8000_0000 / -1 returns q = 0x8000_0000, r = 0 (falls out of the
// magnitude arithmetic, no special handling required).
// ---------------------------------------------------------------------------
module mdu_div
   import mdu_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        is_signed,
   output logic [31:0] q,
   output logic [31:0] r
);

   logic        w_neg_a;
   logic        w_neg_b;
   logic [31:0] w_mag_a;
   logic [31:0] w_mag_b;
   logic [31:0] w_div_b;
   logic [31:0] w_uq;
   logic [31:0] w_ur;

   assign w_neg_a = is_signed & a[31];
   assign w_neg_b = is_signed & b[31];
   assign w_mag_a = w_neg_a ? (~a + 32'd1) : a;
   assign w_mag_b = w_neg_b ? (~b + 32'd1) : b;
   // Keep the core divider away from a zero divisor; the zero case is
   // overridden below anyway.
   assign w_div_b = (b == '0) ? 32'd1 : w_mag_b;
   assign w_uq    = w_mag_a / w_div_b;
   assign w_ur    = w_mag_a % w_div_b;

   always_comb begin
      q = (w_neg_a ^ w_neg_b) ? (~w_uq + 32'd1) : w_uq;
      r = w_neg_a ? (~w_ur + 32'd1) : w_ur;
      if (b == '0) begin
         q = '1;
         r = a;
      end
   end

endmodule

// File: rtl/mdu_seq.sv
// ---------------------------------------------------------------------------
// mdu_seq
// Multi-cycle MIPS-style HI/LO multiply/divide unit. The result is computed
// at issue and held in pend_hi/pend_lo; HI/LO are written when busy falls.
//   MULT_CYCLES   param     busy cycles for MULT/MULTU (1..15)
//   DIV_CYCLES    param     busy cycles for DIV/DIVU   (1..15)
//   clk           in  1     rising-edge clock
//   reset         in  1     asynchronous active-low reset
//   start         in  1     MD instruction valid in E
//   op            in  3     MD_* opcode (mdu_pkg)
//   rs, rt        in  32    forwarded operands
//   int_req       in  1     E-stage flush; blocks a new issue only
//   busy          out 1     registered, high while MULT/DIV in flight
//   hi, lo        out 32    architectural HI/LO
// ---------------------------------------------------------------------------
module mdu_seq
   import mdu_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   input  logic        int_req,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   mdu_state_t        r_state, w_state_n;
   logic [CNT_W-1:0]  r_cnt, w_cnt_n;
   logic              r_busy, w_busy_n;
   logic [31:0]       r_hi, w_hi_n;
   logic [31:0]       r_lo, w_lo_n;
   logic [31:0]       r_pend_hi, w_pend_hi_n;
   logic [31:0]       r_pend_lo, w_pend_lo_n;

   logic              w_issue;
   logic              w_signed;
   logic [63:0]       w_mul_a;
   logic [63:0]       w_mul_b;
   logic [63:0]       w_prod;
   logic [31:0]       w_div_q;
   logic [31:0]       w_div_r;

   assign w_issue  = start & ~int_req & (r_state == ST_IDLE);
   assign w_signed = (op == MD_MULT) || (op == MD_DIV);

   // One 64x64 multiplier serves both flavours: operands are sign- or
   // zero-extended, and the low 64 bits of the product are exact either way.
   assign w_mul_a = {{32{w_signed & rs[31]}}, rs};
   assign w_mul_b = {{32{w_signed & rt[31]}}, rt};
   assign w_prod  = w_mul_a * w_mul_b;

   mdu_div u_div (
      .a         (rs),
      .b         (rt),
      .is_signed (w_signed),
      .q         (w_div_q),
      .r         (w_div_r)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_pend_hi <= '0;
         r_pend_lo <= '0;
      end else begin
         r_state   <= w_state_n;
         r_cnt     <= w_cnt_n;
         r_busy    <= w_busy_n;
         r_hi      <= w_hi_n;
         r_lo      <= w_lo_n;
         r_pend_hi <= w_pend_hi_n;
         r_pend_lo <= w_pend_lo_n;
      end
   end

   always_comb begin
      w_state_n   = r_state;
      w_cnt_n     = r_cnt;
      w_busy_n    = r_busy;
      w_hi_n      = r_hi;
      w_lo_n      = r_lo;
      w_pend_hi_n = r_pend_hi;
      w_pend_lo_n = r_pend_lo;

      case (r_state)
         ST_IDLE: begin
            if (w_issue) begin
               case (op)
                  MD_MULT, MD_MULTU: begin
                     w_state_n   = ST_MUL;
                     w_cnt_n     = CNT_W'(MULT_CYCLES);
                     w_busy_n    = 1'b1;
                     w_pend_hi_n = w_prod[63:32];
                     w_pend_lo_n = w_prod[31:0];
                  end
                  MD_DIV, MD_DIVU: begin
                     w_state_n   = ST_DIV;
                     w_cnt_n     = CNT_W'(DIV_CYCLES);
                     w_busy_n    = 1'b1;
                     w_pend_hi_n = w_div_r;
                     w_pend_lo_n = w_div_q;
                  end
                  MD_MTHI: w_hi_n = rs;
                  MD_MTLO: w_lo_n = rs;
                  default: ;
               endcase
            end
         end
         ST_MUL, ST_DIV: begin
            // Counter counts N..1; the edge that sees 1 drops busy and
            // commits the pending result together.
            if (r_cnt == CNT_W'(1)) begin
               w_state_n = ST_IDLE;
               w_cnt_n   = '0;
               w_busy_n  = 1'b0;
               w_hi_n    = r_pend_hi;
               w_lo_n    = r_pend_lo;
            end else begin
               w_cnt_n   = r_cnt - CNT_W'(1);
            end
         end
         default: begin
            w_state_n = ST_IDLE;
            w_cnt_n   = '0;
            w_busy_n  = 1'b0;
         end
      endcase
   end

   assign busy = r_busy;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_seq.sv
// ---------------------------------------------------------------------------
// tb_mdu_seq
// Self-checking bench for mdu_seq: directed cases plus randomized operations
// checked against an arithmetic reference model of HI/LO behaviour.
// ---------------------------------------------------------------------------
module tb_mdu_seq;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs;
   logic [31:0] rt;
   logic        int_req;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   logic [31:0] m_hi    = '0;
   logic [31:0] m_lo    = '0;

   always #5 clk = ~clk;

   mdu_seq #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .rs      (rs),
      .rt      (rt),
      .int_req (int_req),
      .busy    (busy),
      .hi      (hi),
      .lo      (lo)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: architectural {HI,LO} after the op completes.
   function automatic logic [63:0] ref_result(input logic [2:0] f_op,
                                              input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] cur_hi, input logic [31:0] cur_lo);
      longint          sa, sb, sq, sr;
      longint unsigned ua, ub;
      logic [63:0]     res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'(a);
      ub = longint'(b);
      res = {cur_hi, cur_lo};
      case (f_op)
         MD_MULT:  res = sa * sb;
         MD_MULTU: res = ua * ub;
         MD_DIV: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else begin
               sq = sa / sb;
               sr = sa % sb;
               res = {sr[31:0], sq[31:0]};
            end
         end
         MD_DIVU: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else res = {32'(ua % ub), 32'(ua / ub)};
         end
         MD_MTHI:  res = {a, cur_lo};
         MD_MTLO:  res = {cur_hi, a};
         default:  res = {cur_hi, cur_lo};
      endcase
      return res;
   endfunction

   function automatic int latency(input logic [2:0] f_op);
      if (f_op == MD_MULT || f_op == MD_MULTU) return 5;
      if (f_op == MD_DIV  || f_op == MD_DIVU)  return 10;
      return 0;
   endfunction

   // Issue one op and follow it to completion. int_at / start_at give the
   // busy-cycle index at which to pulse int_req / a stray MULT 3*4 (-1: none).
   task automatic do_op(input logic [2:0] t_op, input logic [31:0] a, input logic [31:0] b,
                        input bit no_wait, input int int_at, input int start_at);
      logic [63:0] exp;
      int          n;
      exp = ref_result(t_op, a, b, m_hi, m_lo);
      n   = latency(t_op);
      if (!no_wait) @(negedge clk);
      start = 1'b1; op = t_op; rs = a; rt = b; int_req = 1'b0;
      @(negedge clk);
      start = 1'b0; rs = $urandom; rt = $urandom;
      for (int k = 0; k < n; k++) begin
         int_req = (k == int_at);
         start   = (k == start_at);
         if (k == start_at) begin
            op = MD_MULT; rs = 32'd3; rt = 32'd4;
         end
         chk("busy_high", 64'(busy), 64'd1);
         chk("hilo_hold", {hi, lo}, {m_hi, m_lo});
         @(negedge clk);
      end
      start = 1'b0; int_req = 1'b0;
      chk("busy_low", 64'(busy), 64'd0);
      chk("result", {hi, lo}, exp);
      m_hi = exp[63:32];
      m_lo = exp[31:0];
   endtask

   initial begin
      logic [2:0]  r_op;
      logic [31:0] a, b;
      int          sel, ia;

      reset = 1'b0; start = 1'b0; op = MD_MULT; rs = '0; rt = '0; int_req = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_hilo", {hi, lo}, 64'd0);

      // First issue on the first edge after release; MULT -2*3.
      reset = 1'b1;
      do_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1, -1, -1);
      chk("mult_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);

      do_op(MD_DIVU, 32'd100, 32'd7, 1'b0, -1, -1);
      chk("divu_const", {hi, lo}, {32'd2, 32'd14});
      do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, -1, -1);
      chk("div_neg_const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      do_op(MD_DIV, 32'h1234, 32'd0, 1'b0, -1, -1);
      chk("div_by_zero", {hi, lo}, {32'h1234, 32'hFFFF_FFFF});
      do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1, -1);
      chk("div_overflow", {hi, lo}, {32'd0, 32'h8000_0000});
      do_op(MD_MTHI, 32'hA5A5_A5A5, 32'd0, 1'b0, -1, -1);
      chk("mthi_const", 64'(hi), 64'hA5A5_A5A5);

      // start together with int_req: no issue.
      @(negedge clk);
      start = 1'b1; int_req = 1'b1; op = MD_MULTU; rs = 32'd2; rt = 32'd2;
      @(negedge clk);
      start = 1'b0; int_req = 1'b0;
      chk("blocked_busy", 64'(busy), 64'd0);
      @(negedge clk);
      chk("blocked_busy2", 64'(busy), 64'd0);
      chk("blocked_hilo", {hi, lo}, {m_hi, m_lo});

      // Stray start in busy cycle 2 is ignored.
      do_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, 1);
      chk("multu_max", {hi, lo}, {32'hFFFF_FFFE, 32'd1});
      // int_req while busy does not abort.
      do_op(MD_DIVU, 32'd1000, 32'd9, 1'b0, 3, -1);

      // Reset in cycle 3 of a DIV discards the pending result.
      @(negedge clk);
      start = 1'b1; op = MD_DIV; rs = 32'd12345; rt = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid_busy", 64'(busy), 64'd1);
      reset = 1'b0;
      #1;
      chk("async_rst_busy", 64'(busy), 64'd0);
      chk("async_rst_hilo", {hi, lo}, 64'd0);
      m_hi = '0; m_lo = '0;
      @(negedge clk);
      reset = 1'b1;
      repeat (12) @(negedge clk);
      chk("post_rst_busy", 64'(busy), 64'd0);
      chk("post_rst_hilo", {hi, lo}, 64'd0);
      do_op(MD_MULT, 32'd3, 32'd4, 1'b0, -1, -1);
      chk("mult_after_rst", {hi, lo}, 64'd12);

      // Randomized operations with occasional corner operands.
      for (int i = 0; i < 30; i++) begin
         r_op = 3'($urandom_range(0, 5));
         a    = $urandom;
         b    = $urandom;
         sel  = int'($urandom_range(0, 7));
         if (sel == 0) b = 32'd0;
         else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         else if (sel == 2) b = 32'($urandom_range(1, 9));
         ia   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
         do_op(r_op, a, b, 1'b0, ia, ($urandom_range(0, 3) == 0) ? 2 : -1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
